// File: rtl/ir_pkg.sv
// ir_pkg -- shared definitions for the instruction queue.
//   * bit positions of every MIPS R/I/J field inside a 32-bit word
//   * opcode_e : the opcodes the multicycle control unit recognises
//   * ir_fields_t : a fully split instruction, as seen by control and datapath
package ir_pkg;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JADDR_HI = 25;
  localparam int JADDR_LO = 0;

  typedef enum logic [5:0] {
    R_TYPE = 6'h00,
    J      = 6'h02,
    JAL    = 6'h03,
    BEQ    = 6'h04,
    BNE    = 6'h05,
    ADDI   = 6'h08,
    LW     = 6'h23,
    SW     = 6'h2B
  } opcode_e;

  typedef struct packed {
    opcode_e     op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] addr_imm;
    logic [31:0] imm_ext;
    logic [25:0] jaddr;
  } ir_fields_t;

endpackage

// File: rtl/instr_queue_if.sv
// instr_queue_if -- fetch/execute side bundle of the instruction queue.
//   master : fetch/control side (drives IRWrite, MemData, Advance, Flush)
//   slave  : the queue itself (drives status and the decoded head fields)
interface instr_queue_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             IRWrite;
  logic [WIDTH-1:0] MemData;
  logic             Advance;
  logic             Flush;
  logic             Valid;
  logic             Full;
  logic [CNT_W-1:0] Count;
  logic             Overflow;
  logic [5:0]       Op;
  logic [4:0]       Rs;
  logic [4:0]       Rt;
  logic [4:0]       Rd;
  logic [4:0]       Shamt;
  logic [5:0]       Funct;
  logic [15:0]      Addr_imm;
  logic [31:0]      Imm_ext;
  logic [25:0]      Jaddr;

  modport master (
    output IRWrite, MemData, Advance, Flush,
    input  Valid, Full, Count, Overflow,
    input  Op, Rs, Rt, Rd, Shamt, Funct, Addr_imm, Imm_ext, Jaddr
  );

  modport slave (
    input  IRWrite, MemData, Advance, Flush,
    output Valid, Full, Count, Overflow,
    output Op, Rs, Rt, Rd, Shamt, Funct, Addr_imm, Imm_ext, Jaddr
  );
endinterface

// File: rtl/ir_field_decode.sv
// ir_field_decode -- purely combinational splitter of one instruction word.
//   word   : 32-bit instruction
//   valid  : when low every field is forced to 0 (an encoded NOP)
//   fields : all R/I/J fields plus the sign-extended immediate
module ir_field_decode
  import ir_pkg::*;
(
  input  logic [31:0] word,
  input  logic        valid,
  output ir_fields_t  fields
);

  always_comb begin
    // NOTE: default every output first so no path through the block leaves
    // a field unassigned; otherwise synthesis infers a latch.
    fields = '0;
    if (valid) begin
      fields.op       = opcode_e'(word[OP_HI:OP_LO]);
      fields.rs       = word[RS_HI:RS_LO];
      fields.rt       = word[RT_HI:RT_LO];
      fields.rd       = word[RD_HI:RD_LO];
      fields.shamt    = word[SHAMT_HI:SHAMT_LO];
      fields.funct    = word[FUNCT_HI:FUNCT_LO];
      fields.addr_imm = word[IMM_HI:IMM_LO];
      fields.imm_ext  = {{16{word[IMM_HI]}}, word[IMM_HI:IMM_LO]};
      fields.jaddr    = word[JADDR_HI:JADDR_LO];
    end
  end

endmodule

// File: rtl/instr_queue.sv
// instr_queue -- instruction register / prefetch queue (circular buffer).
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : instr_queue_if.slave (push/pop/flush in, status and head fields out)
// Optional feature macro IR_BYPASS_EN: when the queue is empty a word being
// pushed is visible on the outputs in the same cycle and may be consumed
// directly by Advance without ever being stored.
module instr_queue
  import ir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  instr_queue_if.slave        bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic             not_empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             consume;
  logic [31:0]      dec_word;
  logic             dec_valid;
  ir_fields_t       fields;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));

`ifdef IR_BYPASS_EN
  logic bypass;
  assign bypass    = !not_empty && bus.IRWrite;
  // Word handed straight to execute; Flush keeps priority and stores it.
  assign consume   = bypass && bus.Advance && !bus.Flush;
  assign dec_word  = bypass ? bus.MemData[WIDTH-1 -: 32] : mem[rd_ptr][WIDTH-1 -: 32];
  assign dec_valid = not_empty || bypass;
`else
  assign consume   = 1'b0;
  assign dec_word  = mem[rd_ptr][WIDTH-1 -: 32];
  assign dec_valid = not_empty;
`endif

  assign pop  = bus.Advance && not_empty && !bus.Flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = bus.IRWrite && !consume && (!full || pop);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.Flush) begin
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      wr_ptr     <= bus.IRWrite ? PTR_W'(1) : '0;
      count_q    <= bus.IRWrite ? CNT_W'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (bus.IRWrite && !push && !consume) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; its contents are never
  // observed while Count says the slot is empty, and a reset would turn the
  // array into flops instead of plain RAM.
  always_ff @(posedge Clk) begin
    if (bus.Flush && bus.IRWrite) mem[0]      <= bus.MemData;
    else if (!bus.Flush && push)  mem[wr_ptr] <= bus.MemData;
  end

  ir_field_decode u_decode (
    .word   (dec_word),
    .valid  (dec_valid),
    .fields (fields)
  );

  assign bus.Valid    = dec_valid;
  assign bus.Full     = full;
  assign bus.Count    = count_q;
  assign bus.Overflow = overflow_q;
  assign bus.Op       = fields.op;
  assign bus.Rs       = fields.rs;
  assign bus.Rt       = fields.rt;
  assign bus.Rd       = fields.rd;
  assign bus.Shamt    = fields.shamt;
  assign bus.Funct    = fields.funct;
  assign bus.Addr_imm = fields.addr_imm;
  assign bus.Imm_ext  = fields.imm_ext;
  assign bus.Jaddr    = fields.jaddr;

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue -- self-checking bench for instr_queue (DEPTH=4, WIDTH=32).
// A queue-of-words reference model predicts every output each cycle; directed
// sequences cover the documented scenarios, then randomized traffic follows.
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  instr_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_q[$];
  bit          model_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit irw, input logic [31:0] d, input bit adv, input bit fl);
    bus.IRWrite = irw;
    bus.MemData = d;
    bus.Advance = adv;
    bus.Flush   = fl;
  endtask

  // Compare every output with what the model says should be visible now.
  task automatic check_outputs(input string ctx);
    bit          v;
    logic [31:0] w;
    logic [31:0] imm;
    v = (model_q.size() > 0);
    w = v ? model_q[0] : 32'h0;
`ifdef IR_BYPASS_EN
    if (!v && bus.IRWrite) begin
      v = 1'b1;
      w = bus.MemData;
    end
`endif
    imm = w & 32'h0000_FFFF;
    check({ctx, ".valid"},    bus.Valid,    v);
    check({ctx, ".full"},     bus.Full,     model_q.size() == DEPTH);
    check({ctx, ".count"},    bus.Count,    model_q.size());
    check({ctx, ".overflow"}, bus.Overflow, model_ovf);
    check({ctx, ".op"},       bus.Op,       (w >> 26) & 32'h3F);
    check({ctx, ".rs"},       bus.Rs,       (w >> 21) & 32'h1F);
    check({ctx, ".rt"},       bus.Rt,       (w >> 16) & 32'h1F);
    check({ctx, ".rd"},       bus.Rd,       (w >> 11) & 32'h1F);
    check({ctx, ".shamt"},    bus.Shamt,    (w >> 6) & 32'h1F);
    check({ctx, ".funct"},    bus.Funct,    w & 32'h3F);
    check({ctx, ".addr_imm"}, bus.Addr_imm, imm);
    check({ctx, ".imm_ext"},  bus.Imm_ext,  (imm >= 32'h8000) ? imm + 32'hFFFF_0000 : imm);
    check({ctx, ".jaddr"},    bus.Jaddr,    w & 32'h03FF_FFFF);
  endtask

  // Reference behaviour at a clock edge, stated in queue terms.
  task automatic model_edge(input bit irw, input logic [31:0] d, input bit adv, input bit fl);
    if (fl) begin
      model_q.delete();
      model_ovf = 1'b0;
      if (irw) model_q.push_back(d);
    end else begin
`ifdef IR_BYPASS_EN
      if (model_q.size() == 0 && irw && adv) return;
`endif
      if (adv && model_q.size() > 0) void'(model_q.pop_front());
      if (irw) begin
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else model_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input bit irw, input logic [31:0] d, input bit adv, input bit fl,
                      input string ctx);
    drive(irw, d, adv, fl);
    #1;
    check_outputs(ctx);
    @(posedge Clk);
    model_edge(irw, d, adv, fl);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    check_outputs("reset");
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // lw $2,4($1)
    step(1'b1, 32'h8C22_0004, 1'b0, 1'b0, "push_lw");
    idle();
    check("lw.valid",   bus.Valid,    1'b1);
    check("lw.op",      bus.Op,       6'h23);
    check("lw.rs",      bus.Rs,       5'd1);
    check("lw.rt",      bus.Rt,       5'd2);
    check("lw.imm",     bus.Addr_imm, 16'h0004);
    check("lw.imm_ext", bus.Imm_ext,  32'h0000_0004);
    check("lw.count",   bus.Count,    3'd1);

    step(1'b1, 32'h1000_FFFF, 1'b0, 1'b0, "push_beq");
    step(1'b1, 32'h0043_0820, 1'b0, 1'b0, "push_add");
    step(1'b0, 32'h0, 1'b1, 1'b0, "pop_lw");
    idle();
    check("beq.imm_ext", bus.Imm_ext, 32'hFFFF_FFFF);
    step(1'b0, 32'h0, 1'b1, 1'b0, "pop_beq");
    idle();
    check("add.rd",    bus.Rd,    5'd1);
    check("add.shamt", bus.Shamt, 5'd0);
    check("add.funct", bus.Funct, 6'h20);
    step(1'b0, 32'h0, 1'b1, 1'b0, "pop_add");
    step(1'b0, 32'h0, 1'b1, 1'b0, "pop_empty");

    // Overfill: five pushes into a four-entry queue.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0C00_0011 + i, 1'b0, 1'b0, "fill");
    idle();
    check("ovf.full",   bus.Full,     1'b1);
    check("ovf.count",  bus.Count,    3'd4);
    check("ovf.flag",   bus.Overflow, 1'b1);
    check("ovf.head",   bus.Jaddr,    26'h000_0011);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("drain.order", bus.Jaddr, 26'h000_0011 + i);
      step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
    end
    idle();
    check("drain.valid",  bus.Valid,    1'b0);
    check("drain.sticky", bus.Overflow, 1'b1);

    // Flush with a simultaneous jump push.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h2000_0100 + i, 1'b0, 1'b0, "pre_flush");
    step(1'b1, 32'h0800_0010, 1'b1, 1'b1, "flush_push");
    idle();
    check("flush.count", bus.Count,    3'd1);
    check("flush.op",    bus.Op,       6'h02);
    check("flush.jaddr", bus.Jaddr,    26'h000_0010);
    check("flush.ovf",   bus.Overflow, 1'b0);

    // Full queue with push+pop each cycle across two pointer wraps.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3000_0000 + i, 1'b0, 1'b0, "refill");
    for (int i = 0; i < 2 * DEPTH; i++) begin
      step(1'b1, 32'h3400_0000 + $urandom_range(0, 16'hFFFF), 1'b1, 1'b0, "full_pp");
      idle();
      check("full_pp.count", bus.Count,    3'd4);
      check("full_pp.ovf",   bus.Overflow, 1'b0);
    end

    // Asynchronous reset in the middle of a cycle at Count=2.
    step(1'b0, 32'h0, 1'b0, 1'b1, "clear");
    step(1'b1, 32'h8C22_0008, 1'b0, 1'b0, "pre_rst");
    step(1'b1, 32'h8C22_000C, 1'b0, 1'b0, "pre_rst");
    idle();
    #2;
    Reset = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check("arst.valid", bus.Valid, 1'b0);
    check("arst.count", bus.Count, 3'd0);
    check("arst.op",    bus.Op,    6'h00);
    check("arst.imm",   bus.Imm_ext, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

`ifdef IR_BYPASS_EN
    drive(1'b1, 32'h8C22_0004, 1'b1, 1'b0);
    #1;
    check("bypass.op",    bus.Op,    6'h23);
    check("bypass.valid", bus.Valid, 1'b1);
    @(posedge Clk);
    #1;
    idle();
    check("bypass.count", bus.Count, 3'd0);
`else
    step(1'b1, 32'h8C22_0004, 1'b1, 1'b0, "nobypass");
    idle();
    check("nobypass.count", bus.Count, 3'd1);
`endif

    // Randomized traffic in push-heavy, balanced and pop-heavy phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        bit irw, adv, fl;
        irw = ($urandom_range(0, 9) < (ph == 0 ? 8 : ph == 1 ? 5 : 3));
        adv = ($urandom_range(0, 9) < (ph == 0 ? 3 : ph == 1 ? 5 : 8));
        fl  = ($urandom_range(0, 39) == 0);
        step(irw, $urandom, adv, fl, "rand");
      end
    end
    idle();
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Parametrised instruction register and prefetch queue for the multicycle MIPS datapath. It buffers up to DEPTH fetched instruction words from memory, so fetch can run ahead of execute. The head word is presented to the control unit and datapath already split into every R/I/J field, with a sign-extended immediate. It replaces the single-entry IR and adds flush, occupancy and overflow reporting.

## Interface
- DEPTH, 4, number of instruction entries; power of two, ≥2
- WIDTH, 32, instruction word width; fields are extracted from the top 32 bits
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- IRWrite  in  1  push MemData into the tail
- MemData  in  WIDTH  instruction word from memory
- Advance  in  1  pop the head (instruction consumed)
- Flush  in  1  discard all entries (branch/jump taken)
- Valid  out  1  head entry present
- Full  out  1  Count == DEPTH
- Count  out  $clog2(DEPTH+1)  occupancy
- Overflow  out  1  sticky: a push was dropped because the queue was full
- Op  out  6  head[31:26]
- Rs  out  5  head[25:21]
- Rt  out  5  head[20:16]
- Rd  out  5  head[15:11]
- Shamt  out  5  head[10:6]
- Funct  out  6  head[5:0]
- Addr_imm  out  16  head[15:0]
- Imm_ext  out  32  Addr_imm sign-extended
- Jaddr  out  26  head[25:0]

## Operation
- Storage is a circular buffer: rd_ptr and wr_ptr are each log2(DEPTH) bits and wrap modulo DEPTH. The count register is separate.
- Push: when IRWrite=1 and not Full, MemData is written at wr_ptr, wr_ptr increments and Count increments.
- Push when Full: the word is dropped and Overflow is set. If Advance is also asserted in that cycle, the push is accepted and no overflow occurs.
- Pop: when Advance=1 and Valid, rd_ptr increments and Count decrements. Advance while empty is ignored.
- Simultaneous push and pop with 0 < Count: both are performed and Count is unchanged.
- Flush: the pointers and Count go to 0 and Overflow is cleared. A push in the same cycle is stored as the sole entry, giving Count=1 with that word at the head. Advance in the same cycle is ignored.
- Fields are decoded combinationally from the head entry. When Valid=0, all field outputs are 0 (an encoded NOP).
- Overflow clears only on Flush or Reset.

## Timing
- Reset (asynchronous, Reset=0): Count=0, Valid=0, Full=0, Overflow=0, all fields 0, pointers 0. Storage contents are don't-care.
- Reset asserted mid-operation takes effect immediately and is not clock-qualified. Deassertion is synchronised externally.
- Push-to-head latency is 1 cycle: a word pushed at edge k into an empty queue appears on the fields after edge k.
- Full, Valid and Count are registered-state derived and update on the same edge as the pointers.
- Pop takes effect at the edge. The next head is visible immediately after it.

## Configuration
- IR_BYPASS_EN defined: when the queue is empty and IRWrite=1, the fields, Imm_ext and Valid reflect MemData combinationally in the same cycle. If Advance is also 1, the word is consumed without being stored, and Count stays 0.
- IR_BYPASS_EN undefined: there is no combinational path from MemData to the outputs. Advance on an empty queue is ignored even if IRWrite=1, and the pushed word is stored.

## Structure
- Package ir_pkg holds:
  - the field bit-position localparams (OP_HI/LO, RS_HI/LO, RT, RD, SHAMT, FUNCT, IMM, JADDR)
  - an opcode_e enum (R_TYPE=6'h00, J=6'h02, BEQ=6'h04, LW=6'h23, SW=6'h2B, ...)
  - an ir_fields_t packed struct
- Sub-module ir_field_decode is combinational: a word and a valid flag go in, ir_fields_t comes out, including the sign extension. It is shared with the bypass path.
- The top level instr_queue holds the pointers, count, storage and overflow flag.

## Test plan
- Reset, then push 0x8C220004 (lw $2,4($1)) → next cycle: Valid=1, Op=0x23, Rs=1, Rt=2, Addr_imm=0x0004, Imm_ext=0x00000004, Count=1.
- Push 0x1000FFFF (beq) → Imm_ext=0xFFFFFFFF. Push 0x00430820 (add $1,$2,$3) → Rd=1, Shamt=0, Funct=0x20.
- DEPTH=4: push 5 distinct words with no Advance → Full=1, Count=4, Overflow=1, head is the first word. Then pop 4 → words come out in order and Valid=0.
- Count=3, then Flush with IRWrite of 0x08000010 in the same cycle → Count=1, Op=0x02, Jaddr=0x0000010, Overflow=0.
- Full queue with push and Advance in the same cycle → Count stays 4, Overflow stays 0. Repeat for 2·DEPTH cycles to check pointer wrap.
- Assert Reset mid-cycle at Count=2 → all outputs 0 before the next edge. With IR_BYPASS_EN, on an empty queue with IRWrite and Advance both high, the same-cycle Op matches MemData and Count stays 0.
